grid_checker: RTL and testbench
===============================

GRID_CHECKER -- requirements
Module: grid_checker

Interface
REQ-001 SHALL have parameter ORD, default 3, the sudoku order; derived LEN = ORD*ORD, AREA = LEN*LEN, IW = $clog2(AREA).
REQ-002 SHALL have port clock  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rq_start  input  1  request to begin or restart a check.
REQ-005 SHALL have port in_valid  input  1  in_value holds a cell value.
REQ-006 SHALL have port in_ready  output  1  checker accepts a cell this cycle.
REQ-007 SHALL have port in_value  input  LEN  one-hot cell value, bit k = value k+1.
REQ-008 SHALL have port done  output  1  check complete.
REQ-009 SHALL have port success  output  1  completed grid is a legal solution.
REQ-010 SHALL have port err_index  output  IW  row-major index of the first failing cell.

Function
REQ-011 SHALL implement states IDLE, RECV, DONE_SUCCESS, DONE_FAILURE.
REQ-012 SHALL go IDLE->RECV on rq_start, and also DONE_*->RECV on rq_start; each entry to RECV clears the cell counter, occupancy and err_index.
REQ-013 SHALL drive in_ready=1 only in RECV and not on a cycle where rq_start=1.
REQ-014 SHALL accept one cell per rising edge where in_valid & in_ready; cells arrive in row-major order, index 0..AREA-1.
REQ-015 SHALL tolerate any number of idle cycles between beats; in_valid=0 leaves all state unchanged.
REQ-016 SHALL track row/column counters (0..LEN-1, column wraps to 0 and increments row) and block = (row/ORD)*ORD + col/ORD, with no division in the datapath.
REQ-017 SHALL keep LEN-bit occupancy registers rowhas[LEN], colhas[LEN], blkhas[LEN], ORing each accepted in_value into its row, column and block.
REQ-018 SHALL flag an accepted cell illegal if in_value is not exactly one-hot (zero or multiple bits set) or if in_value & (rowhas[row] | colhas[col] | blkhas[blk]) != 0.
REQ-019 SHALL, on an illegal accepted cell, load err_index with that cell's index and enter DONE_FAILURE on the same edge.
REQ-020 SHALL, when cell AREA-1 is accepted and is legal, enter DONE_SUCCESS on the same edge, with err_index left at 0.
REQ-021 SHALL assert done and success from registered state only: done=1 in DONE_*, success=1 only in DONE_SUCCESS; both are visible the cycle after the deciding beat.
REQ-022 SHALL accept no beats while in DONE_* states.
REQ-023 SHALL hold done, success and err_index stable in DONE_* until rq_start or reset.
REQ-024 SHALL treat rq_start in RECV as an abort: restart from cell 0 on the next edge, discarding any coincident beat (in_ready is 0 that cycle).
REQ-025 SHALL leave occupancy contents and the counter beyond AREA-1 unobservable, because DONE_* is entered first.

Reset
REQ-026 SHALL, while reset=0 and regardless of clock, force state=IDLE, counters=0, occupancy=0, err_index=0, in_ready=0, done=0, success=0.
REQ-027 SHALL, on reset asserted mid-stream, discard all partial results; after release the block waits in IDLE for rq_start.

Verification (ORD=2, LEN=4, AREA=16; values written as decimal)
REQ-028 SHALL cover: rq_start, then stream 1234/3412/2143/4321 with in_valid=1 -> done=1 and success=1 one cycle after the 16th beat, err_index=0.
REQ-029 SHALL cover: stream 1,1,... -> DONE_FAILURE after beat 1, err_index=1, in_ready=0 afterwards.
REQ-030 SHALL cover: valid grid but cell 5 sent as 4'b0000, and separately as 4'b0011 -> failure, err_index=5.
REQ-031 SHALL cover: row/col-legal but block-duplicate grid 1234/2341/3412/4123 -> failure at cell 4 (value 2 already in block 0), err_index=4.
REQ-032 SHALL cover: valid grid with random in_valid gaps -> same result as REQ-028; no beat is lost or duplicated.
REQ-033 SHALL cover: rq_start after beat 7, then a full valid grid -> success; separately, reset=0 pulsed at beat 9 -> IDLE, all outputs 0.

Source files
------------

// File: rtl/grid_checker.sv
// Streaming sudoku grid checker: accepts cells in row-major order and reports
// whether the completed grid is legal, or the index of the first illegal cell.
module grid_checker #(
  parameter  int ORD  = 3,
  localparam int LEN  = ORD * ORD,
  localparam int AREA = LEN * LEN,
  localparam int IW   = $clog2(AREA)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rq_start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_value,
  output logic           done,
  output logic           success,
  output logic [IW-1:0]  err_index
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int SW = (ORD > 1) ? $clog2(ORD) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE_SUCCESS,
    DONE_FAILURE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   err_q, err_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   blk_q, blk_d;
  logic [CW-1:0]   blk_base_q, blk_base_d;
  logic [SW-1:0]   row_sub_q, row_sub_d;
  logic [SW-1:0]   col_sub_q, col_sub_d;
  logic [LEN-1:0]  rowhas_q [LEN];
  logic [LEN-1:0]  rowhas_d [LEN];
  logic [LEN-1:0]  colhas_q [LEN];
  logic [LEN-1:0]  colhas_d [LEN];
  logic [LEN-1:0]  blkhas_q [LEN];
  logic [LEN-1:0]  blkhas_d [LEN];

  logic            accept;
  logic            illegal;
  logic [LEN-1:0]  seen;

  assign in_ready  = (state_q == RECV) && !rq_start;
  assign accept    = in_valid && in_ready;
  assign seen      = rowhas_q[row_q] | colhas_q[col_q] | blkhas_q[blk_q];
  assign illegal   = !$onehot(in_value) || ((in_value & seen) != '0);
  assign done      = (state_q == DONE_SUCCESS) || (state_q == DONE_FAILURE);
  assign success   = (state_q == DONE_SUCCESS);
  assign err_index = err_q;

  // Block index is tracked incrementally: blk_base is the first block of the
  // current block-row, and sub-counters mark when a block boundary is crossed.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    row_d      = row_q;
    col_d      = col_q;
    blk_d      = blk_q;
    blk_base_d = blk_base_q;
    row_sub_d  = row_sub_q;
    col_sub_d  = col_sub_q;
    rowhas_d   = rowhas_q;
    colhas_d   = colhas_q;
    blkhas_d   = blkhas_q;

    if (rq_start) begin
      state_d    = RECV;
      idx_d      = '0;
      err_d      = '0;
      row_d      = '0;
      col_d      = '0;
      blk_d      = '0;
      blk_base_d = '0;
      row_sub_d  = '0;
      col_sub_d  = '0;
      for (int i = 0; i < LEN; i++) begin
        rowhas_d[i] = '0;
        colhas_d[i] = '0;
        blkhas_d[i] = '0;
      end
    end else if (accept) begin
      if (illegal) begin
        err_d   = idx_q;
        state_d = DONE_FAILURE;
      end else begin
        rowhas_d[row_q] = rowhas_q[row_q] | in_value;
        colhas_d[col_q] = colhas_q[col_q] | in_value;
        blkhas_d[blk_q] = blkhas_q[blk_q] | in_value;
        if (idx_q == IW'(AREA - 1)) begin
          state_d = DONE_SUCCESS;
        end else begin
          idx_d = idx_q + IW'(1);
          if (col_q == CW'(LEN - 1)) begin
            col_d     = '0;
            col_sub_d = '0;
            row_d     = row_q + CW'(1);
            if (row_sub_q == SW'(ORD - 1)) begin
              row_sub_d  = '0;
              blk_base_d = blk_base_q + CW'(ORD);
              blk_d      = blk_base_q + CW'(ORD);
            end else begin
              row_sub_d = row_sub_q + SW'(1);
              blk_d     = blk_base_q;
            end
          end else begin
            col_d = col_q + CW'(1);
            if (col_sub_q == SW'(ORD - 1)) begin
              col_sub_d = '0;
              blk_d     = blk_q + CW'(1);
            end else begin
              col_sub_d = col_sub_q + SW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      err_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      blk_q      <= '0;
      blk_base_q <= '0;
      row_sub_q  <= '0;
      col_sub_q  <= '0;
      for (int i = 0; i < LEN; i++) begin
        rowhas_q[i] <= '0;
        colhas_q[i] <= '0;
        blkhas_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      row_q      <= row_d;
      col_q      <= col_d;
      blk_q      <= blk_d;
      blk_base_q <= blk_base_d;
      row_sub_q  <= row_sub_d;
      col_sub_q  <= col_sub_d;
      for (int i = 0; i < LEN; i++) begin
        rowhas_q[i] <= rowhas_d[i];
        colhas_q[i] <= colhas_d[i];
        blkhas_q[i] <= blkhas_d[i];
      end
    end
  end

endmodule

// File: tb/tb_grid_checker.sv
// Directed bench for grid_checker at ORD=2: legal grids, row/block duplicates,
// malformed one-hot cells, idle gaps, abort and mid-stream reset.
module tb_grid_checker;
  localparam int ORD  = 2;
  localparam int LEN  = 4;
  localparam int AREA = 16;
  localparam int IW   = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           rq_start;
  logic           in_valid;
  logic           in_ready;
  logic [LEN-1:0] in_value;
  logic           done;
  logic           success;
  logic [IW-1:0]  err_index;

  logic [LEN-1:0] grid [AREA];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  grid_checker #(.ORD(ORD)) dut (
    .clock     (clock),
    .reset     (reset),
    .rq_start  (rq_start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .done      (done),
    .success   (success),
    .err_index (err_index)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [LEN-1:0] oh(input int v);
    logic [LEN-1:0] one;
    one = 1;
    return one << (v - 1);
  endfunction

  task automatic set_grid(input int r0, input int r1, input int r2, input int r3);
    int rows [4];
    rows = '{r0, r1, r2, r3};
    for (int r = 0; r < 4; r++) begin
      grid[r*4 + 0] = oh(rows[r] / 1000);
      grid[r*4 + 1] = oh((rows[r] / 100) % 10);
      grid[r*4 + 2] = oh((rows[r] / 10) % 10);
      grid[r*4 + 3] = oh(rows[r] % 10);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    rq_start = 1'b1;
    #1;
    check_eq("ready_during_start", in_ready, 0);
    next_cycle();
    rq_start = 1'b0;
    check_eq("done_after_start", done, 0);
    check_eq("err_after_start", err_index, 0);
  endtask

  task automatic stream(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_value = LEN'($urandom);
          next_cycle();
        end
      end
      in_valid = 1'b1;
      in_value = grid[i];
      #1;
      check_eq($sformatf("ready_beat%0d", i), in_ready, 1);
      next_cycle();
    end
    in_valid = 1'b0;
    in_value = '0;
  endtask

  task automatic check_out(input string tag, input bit e_done, input bit e_succ, input int e_err);
    check_eq({tag, "_done"}, done, e_done);
    check_eq({tag, "_success"}, success, e_succ);
    check_eq({tag, "_err"}, err_index, e_err);
    if (e_done) check_eq({tag, "_ready"}, in_ready, 0);
  endtask

  task automatic hold_and_check(input string tag, input bit e_done, input bit e_succ, input int e_err);
    in_valid = 1'b1;
    in_value = grid[0];
    repeat (3) next_cycle();
    in_valid = 1'b0;
    check_out(tag, e_done, e_succ, e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    rq_start = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    #12;
    check_out("reset", 0, 0, 0);
    check_eq("reset_ready", in_ready, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    next_cycle();
    hold_and_check("idle", 0, 0, 0);
    check_eq("idle_ready", in_ready, 0);

    // Legal grid, no gaps
    set_grid(1234, 3412, 2143, 4321);
    pulse_start();
    stream(0, 14, 0);
    check_out("legal_beat15", 0, 0, 0);
    stream(15, 15, 0);
    check_out("legal", 1, 1, 0);
    hold_and_check("legal_hold", 1, 1, 0);

    // Row duplicate at cell 1
    grid[0] = oh(1);
    grid[1] = oh(1);
    pulse_start();
    stream(0, 0, 0);
    check_out("dup_beat0", 0, 0, 0);
    stream(1, 1, 0);
    check_out("dup", 1, 0, 1);
    hold_and_check("dup_hold", 1, 0, 1);

    // Cell 5 zero, then two bits set
    set_grid(1234, 3412, 2143, 4321);
    grid[5] = 4'b0000;
    pulse_start();
    stream(0, 5, 0);
    check_out("zero_cell", 1, 0, 5);
    grid[5] = 4'b0011;
    pulse_start();
    stream(0, 5, 0);
    check_out("multi_cell", 1, 0, 5);

    // Rows and columns legal, block 0 duplicate at cell 4
    set_grid(1234, 2341, 3412, 4123);
    pulse_start();
    stream(0, 3, 0);
    check_out("blk_beat3", 0, 0, 0);
    stream(4, 4, 0);
    check_out("blk_dup", 1, 0, 4);

    // Legal grid with random idle gaps
    set_grid(1234, 3412, 2143, 4321);
    pulse_start();
    stream(0, 15, 1);
    check_out("gaps", 1, 1, 0);

    // Abort after 7 beats with a coincident beat, then a full grid
    pulse_start();
    stream(0, 6, 0);
    rq_start = 1'b1;
    in_valid = 1'b1;
    in_value = grid[7];
    #1;
    check_eq("abort_ready", in_ready, 0);
    next_cycle();
    rq_start = 1'b0;
    in_valid = 1'b0;
    check_out("abort", 0, 0, 0);
    stream(0, 15, 0);
    check_out("after_abort", 1, 1, 0);

    // Reset mid-stream after 9 beats
    pulse_start();
    stream(0, 8, 0);
    #2;
    reset = 1'b0;
    #1;
    check_out("midreset", 0, 0, 0);
    check_eq("midreset_ready", in_ready, 0);
    repeat (2) @(posedge clock);
    #1;
    check_out("midreset_held", 0, 0, 0);
    reset = 1'b1;
    next_cycle();
    hold_and_check("post_reset_idle", 0, 0, 0);
    check_eq("post_reset_ready", in_ready, 0);
    pulse_start();
    stream(0, 15, 0);
    check_out("post_reset_grid", 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
